// File: rtl/hydra_pkg.sv
// Shared constants and state encoding for the port select driver.
// Defaults here are the production build; the top can override them.
package hydra_pkg;

  localparam int PORT_NUM = 16;
  localparam int IDX_W    = 4;
  localparam int TO_W     = 8;
  localparam int TIMEOUT  = 200;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

endpackage

// File: rtl/idx_to_onehot.sv
// Combinational index to one-hot decoder.
// Indices with no matching port decode to all-zero.
module idx_to_onehot #(
  parameter int PORT_NUM = 16,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    idx_i,
  output logic [PORT_NUM-1:0] onehot_o
);

  // one compare per port; out-of-range indices match nothing
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (idx_i == IDX_W'(i)) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/port_select_driver.sv
// Turns a granted port index into a held one-hot select strobe,
// released by the port's ack or a timeout, with a completion report.
module port_select_driver #(
  parameter int PORT_NUM = hydra_pkg::PORT_NUM,
  parameter int IDX_W    = hydra_pkg::IDX_W,
  parameter int TO_W     = hydra_pkg::TO_W,
  parameter int TIMEOUT  = hydra_pkg::TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IDX_W-1:0]    in_idx,
  output logic                in_ready,
  output logic [PORT_NUM-1:0] select,
  input  logic [PORT_NUM-1:0] port_ack,
  output logic                done_valid,
  output logic [IDX_W-1:0]    done_idx,
  output logic                done_timeout,
  output logic                done_badidx,
  output logic                stray_ack_err
);

  import hydra_pkg::*;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [PORT_NUM-1:0] sel_q, sel_d;
  logic                dv_q, dv_d;
  logic [IDX_W-1:0]    didx_q, didx_d;
  logic                dto_q, dto_d;
  logic                dbad_q, dbad_d;
  logic                stray_q, stray_d;

  logic [PORT_NUM-1:0] dec;
  logic                accept;
  logic                in_range;
  logic                ack_hit;

  idx_to_onehot #(
    .PORT_NUM (PORT_NUM),
    .IDX_W    (IDX_W)
  ) u_dec (
    .idx_i    (in_idx),
    .onehot_o (dec)
  );

  // the decoder yields zero exactly when the index names no port
  assign in_range = |dec;
  assign accept   = in_valid & (state_q == IDLE);
  assign ack_hit  = |(port_ack & sel_q);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // datapath and report registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      dv_q    <= 1'b0;
      didx_q  <= '0;
      dto_q   <= 1'b0;
      dbad_q  <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dv_q    <= dv_d;
      didx_q  <= didx_d;
      dto_q   <= dto_d;
      dbad_q  <= dbad_d;
      stray_q <= stray_d;
    end
  end

  // next state: ack is checked before the timeout so a tie counts as ack
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dv_d    = 1'b0;
    didx_d  = didx_q;
    dto_d   = dto_q;
    dbad_d  = dbad_q;
    stray_d = stray_q;
    unique case (state_q)
      IDLE: begin
        if (accept && in_range) begin
          idx_d   = in_idx;
          cnt_d   = '0;
          sel_d   = dec;
          state_d = ACTIVE;
        end else if (accept) begin
          dv_d   = 1'b1;
          didx_d = in_idx;
          dto_d  = 1'b0;
          dbad_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (|(port_ack & ~sel_q)) stray_d = 1'b1;
        if (ack_hit || cnt_q == TO_LAST) begin
          sel_d   = '0;
          dv_d    = 1'b1;
          didx_d  = idx_q;
          dto_d   = ~ack_hit;
          dbad_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    in_ready      = (state_q == IDLE);
    select        = sel_q;
    done_valid    = dv_q;
    done_idx      = didx_q;
    done_timeout  = dto_q;
    done_badidx   = dbad_q;
    stray_ack_err = stray_q;
  end

endmodule

// File: tb/tb_port_select_driver.sv
// Scoreboard bench for port_select_driver: expected completions are
// queued at issue and matched against done pulses and select width.
module tb_port_select_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_idx;
  logic        in_ready;
  logic [15:0] select;
  logic [15:0] port_ack;
  logic        done_valid;
  logic [3:0]  done_idx;
  logic        done_timeout;
  logic        done_badidx;
  logic        stray_ack_err;

  logic        in_valid2;
  logic [3:0]  in_idx2;
  logic        in_ready2;
  logic [11:0] select2;
  logic [11:0] port_ack2;
  logic        done_valid2;
  logic [3:0]  done_idx2;
  logic        done_timeout2;
  logic        done_badidx2;
  logic        stray2;

  typedef struct {
    logic [15:0] sel;
    int          width;
    logic [3:0]  idx;
    logic        to;
    logic        bad;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   w;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  port_select_driver dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_idx        (in_idx),
    .in_ready      (in_ready),
    .select        (select),
    .port_ack      (port_ack),
    .done_valid    (done_valid),
    .done_idx      (done_idx),
    .done_timeout  (done_timeout),
    .done_badidx   (done_badidx),
    .stray_ack_err (stray_ack_err)
  );

  port_select_driver #(
    .PORT_NUM (12)
  ) dut12 (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid2),
    .in_idx        (in_idx2),
    .in_ready      (in_ready2),
    .select        (select2),
    .port_ack      (port_ack2),
    .done_valid    (done_valid2),
    .done_idx      (done_idx2),
    .done_timeout  (done_timeout2),
    .done_badidx   (done_badidx2),
    .stray_ack_err (stray2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: select shape and width, done pulses against the queue
  always @(negedge clk) begin
    if (rst) begin
      w = 0;
    end else begin
      if (select != 16'h0) begin
        chk("onehot", $countones(select), 1);
        if (q.size() > 0) chk("sel", select, q[0].sel);
        w++;
      end
      if (done_valid) begin
        if (q.size() == 0) begin
          chk("spurious_done", done_valid, 0);
        end else begin
          e = q.pop_front();
          chk("done_idx", done_idx, e.idx);
          chk("done_to", done_timeout, e.to);
          chk("done_bad", done_badidx, e.bad);
          chk("sel_width", w, e.width);
          chk("ready_at_done", in_ready, 1);
          chk("sel_gap", select, 0);
        end
        w = 0;
      end
    end
  end

  task automatic wait_done(input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) break;
    end
    chk("drain", q.size(), 0);
  endtask

  // ack_after=0 means never ack (timeout); stray pulses ack[7] early
  task automatic run_cmd(input logic [3:0] idx, input int ack_after,
                         input bit stray);
    exp_t x;
    x.sel   = 16'h1 << idx;
    x.width = (ack_after == 0) ? 200 : ack_after;
    x.idx   = idx;
    x.to    = (ack_after == 0);
    x.bad   = 1'b0;
    q.push_back(x);
    @(negedge clk);
    chk("ready_pre", in_ready, 1);
    in_valid = 1'b1;
    in_idx   = idx;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= ack_after; k++) begin
      @(negedge clk);
      port_ack = 16'h0;
      if (k == 1 && stray) port_ack[7] = 1'b1;
      if (k == ack_after) port_ack[idx] = 1'b1;
      @(posedge clk);
    end
    #1 port_ack = 16'h0;
    wait_done(300);
  endtask

  initial begin
    exp_t x;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_idx    = 4'h0;
    port_ack  = 16'h0;
    in_valid2 = 1'b0;
    in_idx2   = 4'h0;
    port_ack2 = 12'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_sel", select, 0);
    chk("rst_dv", done_valid, 0);
    chk("rst_didx", done_idx, 0);
    chk("rst_dto", done_timeout, 0);
    chk("rst_dbad", done_badidx, 0);
    chk("rst_stray", stray_ack_err, 0);

    run_cmd(4'd5, 3, 1'b0);
    run_cmd(4'd9, 0, 1'b0);
    run_cmd(4'd2, 1, 1'b0);

    x = '{16'h0001, 1, 4'd0, 1'b0, 1'b0};
    q.push_back(x);
    x = '{16'h8000, 1, 4'd15, 1'b0, 1'b0};
    q.push_back(x);
    @(negedge clk);
    port_ack = 16'h0001;
    in_valid = 1'b1;
    in_idx   = 4'd0;
    @(posedge clk);
    #1 in_idx = 4'd15;
    @(posedge clk);
    #1 port_ack = 16'h8000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 port_ack = 16'h0;
    wait_done(20);
    chk("no_stray_yet", stray_ack_err, 0);

    run_cmd(4'd3, 4, 1'b1);
    chk("stray_set", stray_ack_err, 1);
    repeat (3) @(negedge clk);
    chk("stray_sticky", stray_ack_err, 1);

    x = '{16'h0010, 0, 4'd4, 1'b0, 1'b0};
    q.push_back(x);
    @(negedge clk);
    in_valid = 1'b1;
    in_idx   = 4'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sel_pre_rst", select, 16'h0010);
    #2 rst = 1'b1;
    #1;
    chk("sel_async_clr", select, 0);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("dv_in_rst", done_valid, 0);
    end
    chk("stray_rst_clr", stray_ack_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("dv_after_rst", done_valid, 0);
    chk("ready_after_rst", in_ready, 1);
    run_cmd(4'd4, 2, 1'b0);

    @(negedge clk);
    in_valid2 = 1'b1;
    in_idx2   = 4'd13;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    @(negedge clk);
    chk("p12_dv", done_valid2, 1);
    chk("p12_bad", done_badidx2, 1);
    chk("p12_idx", done_idx2, 13);
    chk("p12_to", done_timeout2, 0);
    chk("p12_sel", select2, 0);
    chk("p12_ready", in_ready2, 1);
    @(negedge clk);
    chk("p12_dv_pulse", done_valid2, 0);
    chk("p12_sel2", select2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
